// File: rtl/seq_alu.sv
// seq_alu: registered multi-cycle ALU with the original opcode map plus signed divide.
//   Single-cycle ops (add/sub/shift/logic/slt) and illegal opcodes complete on the
//   accepting edge, and DONE is high for the following cycle. Signed multiply and
//   divide run one bit per cycle for DATA_WIDTH cycles under START/BUSY/DONE.
// Ports:
//   CLK, RST    clock; synchronous active-high reset
//   START       request, sampled only while BUSY=0
//   OPRN        opcode (low 4 bits decoded; nonzero upper bits are illegal)
//   OP1, OP2    operands, latched on an accepted START
//   BUSY        iterative op in progress
//   DONE        one-cycle pulse: OUT/HI/ZERO/ERR updated
//   OUT, HI     result low / high (product HI or remainder; 0 for other ops)
//   ZERO        registered OUT==0
//   ERR         illegal opcode or divide by zero
module seq_alu #(
  parameter int DATA_WIDTH = 32,
  parameter int OPRN_WIDTH = 6
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  START,
  input  logic [OPRN_WIDTH-1:0] OPRN,
  input  logic [DATA_WIDTH-1:0] OP1,
  input  logic [DATA_WIDTH-1:0] OP2,
  output logic                  BUSY,
  output logic                  DONE,
  output logic [DATA_WIDTH-1:0] OUT,
  output logic [DATA_WIDTH-1:0] HI,
  output logic                  ZERO,
  output logic                  ERR
);

  localparam int N  = DATA_WIDTH;
  localparam int CW = (N > 2) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LP_LAST = CW'(N - 1);
  localparam logic [N-1:0]  LP_NVAL = N'(N);

  localparam logic [3:0] OP_ADD = 4'h1;
  localparam logic [3:0] OP_SUB = 4'h2;
  localparam logic [3:0] OP_MUL = 4'h3;
  localparam logic [3:0] OP_SHR = 4'h4;
  localparam logic [3:0] OP_SHL = 4'h5;
  localparam logic [3:0] OP_AND = 4'h6;
  localparam logic [3:0] OP_OR  = 4'h7;
  localparam logic [3:0] OP_NOR = 4'h8;
  localparam logic [3:0] OP_SLT = 4'h9;
  localparam logic [3:0] OP_DIV = 4'hA;

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV} state_t;

  state_t          r_state,  w_state_n;
  logic [CW-1:0]   r_cnt,    w_cnt_n;
  logic [2*N:0]    r_p,      w_p_n;       // mul: {acc, multiplier}; div: {remainder, dividend/quotient}
  logic [N-1:0]    r_b,      w_b_n;       // multiplicand or divisor magnitude
  logic            r_neg_lo, w_neg_lo_n;  // negate product / quotient
  logic            r_neg_hi, w_neg_hi_n;  // negate remainder (dividend sign)
  logic            r_dz,     w_dz_n;
  logic [N-1:0]    r_op1,    w_op1_n;
  logic            r_busy,   w_busy_n;
  logic            r_done,   w_done_n;
  logic [N-1:0]    r_out,    w_out_n;
  logic [N-1:0]    r_hi,     w_hi_n;
  logic            r_zero,   w_zero_n;
  logic            r_err,    w_err_n;

  logic            w_upper_nz;
  logic [3:0]      w_opc;
  logic [N-1:0]    w_mag1, w_mag2;
  logic [N-1:0]    w_shr, w_shl;
  logic            w_slt;
  logic [N:0]      w_mul_sum;
  logic [2*N:0]    w_mul_step;
  logic [2*N-1:0]  w_mul_res;
  logic [N:0]      w_div_sh, w_div_rem;
  logic            w_div_ge;
  logic [2*N:0]    w_div_step;
  logic [N-1:0]    w_quo, w_rem;

  // Nonzero upper opcode bits fold onto 0x0, which decodes as illegal.
  assign w_upper_nz = (OPRN >> 4) != '0;
  assign w_opc      = w_upper_nz ? 4'h0 : OPRN[3:0];

  // Magnitudes are unsigned, so the most-negative value maps to 2^(N-1) exactly.
  assign w_mag1 = OP1[N-1] ? -OP1 : OP1;
  assign w_mag2 = OP2[N-1] ? -OP2 : OP2;

  assign w_shr = (OP2 >= LP_NVAL) ? '0 : (OP1 >> OP2);
  assign w_shl = (OP2 >= LP_NVAL) ? '0 : (OP1 << OP2);
  assign w_slt = $signed(OP1) < $signed(OP2);

  // Shift-add: add multiplicand when multiplier LSB is set, then shift right.
  assign w_mul_sum  = r_p[2*N:N] + (r_p[0] ? {1'b0, r_b} : '0);
  assign w_mul_step = {1'b0, w_mul_sum, r_p[N-1:1]};
  assign w_mul_res  = r_neg_lo ? -w_mul_step[2*N-1:0] : w_mul_step[2*N-1:0];

  // Restoring divide: shift the next dividend bit into the remainder, subtract if it fits.
  assign w_div_sh   = {r_p[2*N-1:N], r_p[N-1]};
  assign w_div_ge   = w_div_sh >= {1'b0, r_b};
  assign w_div_rem  = w_div_ge ? (w_div_sh - {1'b0, r_b}) : w_div_sh;
  assign w_div_step = {w_div_rem, r_p[N-2:0], w_div_ge};
  assign w_quo      = r_neg_lo ? -w_div_step[N-1:0]     : w_div_step[N-1:0];
  assign w_rem      = r_neg_hi ? -w_div_step[2*N-1:N]   : w_div_step[2*N-1:N];

  always_comb begin
    w_state_n  = r_state;
    w_cnt_n    = r_cnt;
    w_p_n      = r_p;
    w_b_n      = r_b;
    w_neg_lo_n = r_neg_lo;
    w_neg_hi_n = r_neg_hi;
    w_dz_n     = r_dz;
    w_op1_n    = r_op1;
    w_busy_n   = r_busy;
    w_done_n   = 1'b0;
    w_out_n    = r_out;
    w_hi_n     = r_hi;
    w_err_n    = r_err;

    case (r_state)
      S_IDLE: begin
        if (START) begin
          case (w_opc)
            OP_MUL: begin
              w_state_n  = S_MUL;
              w_busy_n   = 1'b1;
              w_cnt_n    = '0;
              w_p_n      = {{(N+1){1'b0}}, w_mag2};
              w_b_n      = w_mag1;
              w_neg_lo_n = OP1[N-1] ^ OP2[N-1];
            end
            OP_DIV: begin
              w_state_n  = S_DIV;
              w_busy_n   = 1'b1;
              w_cnt_n    = '0;
              w_p_n      = {{(N+1){1'b0}}, w_mag1};
              w_b_n      = w_mag2;
              w_neg_lo_n = OP1[N-1] ^ OP2[N-1];
              w_neg_hi_n = OP1[N-1];
              w_dz_n     = (OP2 == '0);
              w_op1_n    = OP1;
            end
            default: begin
              w_done_n = 1'b1;
              w_hi_n   = '0;
              w_err_n  = 1'b0;
              case (w_opc)
                OP_ADD:  w_out_n = OP1 + OP2;
                OP_SUB:  w_out_n = OP1 - OP2;
                OP_SHR:  w_out_n = w_shr;
                OP_SHL:  w_out_n = w_shl;
                OP_AND:  w_out_n = OP1 & OP2;
                OP_OR:   w_out_n = OP1 | OP2;
                OP_NOR:  w_out_n = ~(OP1 | OP2);
                OP_SLT:  w_out_n = {{(N-1){1'b0}}, w_slt};
                default: begin
                  w_out_n = '0;
                  w_err_n = 1'b1;
                end
              endcase
            end
          endcase
        end
      end
      S_MUL: begin
        w_p_n   = w_mul_step;
        w_cnt_n = r_cnt + CW'(1);
        if (r_cnt == LP_LAST) begin
          w_state_n = S_IDLE;
          w_cnt_n   = '0;
          w_busy_n  = 1'b0;
          w_done_n  = 1'b1;
          w_out_n   = w_mul_res[N-1:0];
          w_hi_n    = w_mul_res[2*N-1:N];
          w_err_n   = 1'b0;
        end
      end
      S_DIV: begin
        w_p_n   = w_div_step;
        w_cnt_n = r_cnt + CW'(1);
        if (r_cnt == LP_LAST) begin
          w_state_n = S_IDLE;
          w_cnt_n   = '0;
          w_busy_n  = 1'b0;
          w_done_n  = 1'b1;
          if (r_dz) begin
            w_out_n = '1;
            w_hi_n  = r_op1;
            w_err_n = 1'b1;
          end else begin
            w_out_n = w_quo;
            w_hi_n  = w_rem;
            w_err_n = 1'b0;
          end
        end
      end
      default: begin
        w_state_n = S_IDLE;
        w_busy_n  = 1'b0;
        w_cnt_n   = '0;
      end
    endcase

    w_zero_n = (w_out_n == '0);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_p      <= '0;
      r_b      <= '0;
      r_neg_lo <= 1'b0;
      r_neg_hi <= 1'b0;
      r_dz     <= 1'b0;
      r_op1    <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_out    <= '0;
      r_hi     <= '0;
      r_zero   <= 1'b1;
      r_err    <= 1'b0;
    end else begin
      r_state  <= w_state_n;
      r_cnt    <= w_cnt_n;
      r_p      <= w_p_n;
      r_b      <= w_b_n;
      r_neg_lo <= w_neg_lo_n;
      r_neg_hi <= w_neg_hi_n;
      r_dz     <= w_dz_n;
      r_op1    <= w_op1_n;
      r_busy   <= w_busy_n;
      r_done   <= w_done_n;
      r_out    <= w_out_n;
      r_hi     <= w_hi_n;
      r_zero   <= w_zero_n;
      r_err    <= w_err_n;
    end
  end

  assign BUSY = r_busy;
  assign DONE = r_done;
  assign OUT  = r_out;
  assign HI   = r_hi;
  assign ZERO = r_zero;
  assign ERR  = r_err;

endmodule

// File: tb/tb_seq_alu.sv
// Self-checking bench for seq_alu: directed vector table (32- and 8-bit instances),
// hand-written handshake/reset sequences, and randomized ops against an
// arithmetic reference model.
module tb_seq_alu;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        st32 = 1'b0, st8 = 1'b0;
  logic [5:0]  OPRN = '0;
  logic [31:0] OP1 = '0, OP2 = '0;

  logic        busy32, done32, zero32, err32;
  logic [31:0] out32, hi32;
  logic        busy8, done8, zero8, err8;
  logic [7:0]  out8, hi8;

  int checks = 0;
  int errors = 0;

  always #5 CLK = ~CLK;

  seq_alu #(.DATA_WIDTH(32), .OPRN_WIDTH(6)) dut32 (
    .CLK(CLK), .RST(RST), .START(st32), .OPRN(OPRN), .OP1(OP1), .OP2(OP2),
    .BUSY(busy32), .DONE(done32), .OUT(out32), .HI(hi32), .ZERO(zero32), .ERR(err32)
  );

  seq_alu #(.DATA_WIDTH(8), .OPRN_WIDTH(6)) dut8 (
    .CLK(CLK), .RST(RST), .START(st8), .OPRN(OPRN), .OP1(OP1[7:0]), .OP2(OP2[7:0]),
    .BUSY(busy8), .DONE(done8), .OUT(out8), .HI(hi8), .ZERO(zero8), .ERR(err8)
  );

  typedef struct {
    string       nm;
    bit          w8;
    logic [5:0]  op;
    logic [31:0] a, b, eo, eh;
    logic        ee;
    int          lat;
  } vec_t;

  vec_t tv[$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // Reference model: signed values via sign extension, plain 64-bit arithmetic.
  function automatic void model(input int n, input logic [5:0] op, input logic [31:0] a_in,
                                input logic [31:0] b_in, output logic [31:0] out,
                                output logic [31:0] hi, output logic err, output int lat);
    longint mask, half, a, b, sa, sb, p, lo, hv;
    mask = (longint'(1) << n) - 1;
    half = longint'(1) << (n - 1);
    a = longint'(a_in) & mask;
    b = longint'(b_in) & mask;
    sa = (a ^ half) - half;
    sb = (b ^ half) - half;
    err = 1'b0; lat = 1; lo = 0; hv = 0;
    if (op == 6'h00 || op > 6'h0A) begin
      err = 1'b1;
    end else begin
      case (op[3:0])
        4'h1: lo = a + b;
        4'h2: lo = a - b;
        4'h3: begin p = sa * sb; lo = p; hv = p >>> n; lat = n + 1; end
        4'h4: lo = (b >= n) ? 0 : (a >> b);
        4'h5: lo = (b >= n) ? 0 : (a << b);
        4'h6: lo = a & b;
        4'h7: lo = a | b;
        4'h8: lo = ~(a | b);
        4'h9: lo = (sa < sb) ? 1 : 0;
        default: begin
          lat = n + 1;
          if (b == 0) begin lo = mask; hv = a; err = 1'b1; end
          else begin lo = sa / sb; hv = sa % sb; end
        end
      endcase
    end
    out = 32'(lo & mask);
    hi  = 32'(hv & mask);
  endfunction

  function automatic logic [31:0] pick(input int n);
    logic [31:0] half;
    half = 32'(longint'(1) << (n - 1));
    case ($urandom_range(0, 3))
      0: return $urandom;
      1: return 32'($urandom_range(0, 40));
      2: case ($urandom_range(0, 4))
           0: return 32'h0;
           1: return 32'h1;
           2: return '1;
           3: return half;
           default: return half - 32'h1;
         endcase
      default: return 32'h0 - 32'($urandom_range(1, 20));
    endcase
  endfunction

  task automatic run_op(input bit w8, input logic [5:0] op, input logic [31:0] a,
                        input logic [31:0] b, output logic [31:0] out, output logic [31:0] hi,
                        output logic zero, output logic err, output int lat, output int busyc);
    @(negedge CLK);
    OPRN = op; OP1 = a; OP2 = b;
    if (w8) st8 = 1'b1; else st32 = 1'b1;
    @(posedge CLK); #1;
    st8 = 1'b0; st32 = 1'b0;
    lat = 0; busyc = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge CLK);
      lat++;
      if (w8 ? done8 : done32) break;
      if (w8 ? busy8 : busy32) busyc++;
    end
    out  = w8 ? {24'h0, out8} : out32;
    hi   = w8 ? {24'h0, hi8}  : hi32;
    zero = w8 ? zero8 : zero32;
    err  = w8 ? err8  : err32;
  endtask

  task automatic check_op(input string nm, input bit w8, input logic [5:0] op,
                          input logic [31:0] a, input logic [31:0] b, input logic [31:0] eo,
                          input logic [31:0] eh, input logic ee, input int elat);
    logic [31:0] o, h;
    logic        z, e;
    int          l, bc;
    run_op(w8, op, a, b, o, h, z, e, l, bc);
    chk({nm, "_lat"},  64'(l),  64'(elat));
    chk({nm, "_out"},  64'(o),  64'(eo));
    chk({nm, "_hi"},   64'(h),  64'(eh));
    chk({nm, "_err"},  64'(e),  64'(ee));
    chk({nm, "_zero"}, 64'(z),  64'(eo == 32'h0));
    chk({nm, "_busy"}, 64'(bc), 64'(elat - 1));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] prev;
    int          lat;
    bit          held, got;

    // Reset held with START asserted: nothing may start or complete.
    RST = 1'b1; st32 = 1'b1; st8 = 1'b1; OPRN = 6'h03; OP1 = 32'd3; OP2 = 32'd4;
    for (int i = 0; i < 2; i++) begin
      @(negedge CLK);
      chk("rst_done",  64'(done32), 64'(0));
      chk("rst_busy",  64'(busy32), 64'(0));
      chk("rst_out",   64'(out32),  64'(0));
      chk("rst_hi",    64'(hi32),   64'(0));
      chk("rst_zero",  64'(zero32), 64'(1));
      chk("rst_err",   64'(err32),  64'(0));
      chk("rst_done8", 64'(done8),  64'(0));
    end
    RST = 1'b0; st32 = 1'b0; st8 = 1'b0;

    tv.push_back('{"add_ovf",  0, 6'h01, 32'h7FFFFFFF, 32'h1, 32'h80000000, 32'h0, 1'b0, 1});
    tv.push_back('{"sub_zero", 0, 6'h02, 32'd5, 32'd5, 32'h0, 32'h0, 1'b0, 1});
    tv.push_back('{"slt_neg",  0, 6'h09, 32'hFFFFFFFF, 32'h1, 32'h1, 32'h0, 1'b0, 1});
    tv.push_back('{"slt_ge",   0, 6'h09, 32'h1, 32'hFFFFFFFF, 32'h0, 32'h0, 1'b0, 1});
    tv.push_back('{"shl_32",   0, 6'h05, 32'h1, 32'd32, 32'h0, 32'h0, 1'b0, 1});
    tv.push_back('{"shl_31",   0, 6'h05, 32'h1, 32'd31, 32'h80000000, 32'h0, 1'b0, 1});
    tv.push_back('{"shr_31",   0, 6'h04, 32'h80000000, 32'd31, 32'h1, 32'h0, 1'b0, 1});
    tv.push_back('{"shr_big",  0, 6'h04, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0, 32'h0, 1'b0, 1});
    tv.push_back('{"and",      0, 6'h06, 32'hF0F0, 32'hFF00, 32'hF000, 32'h0, 1'b0, 1});
    tv.push_back('{"or",       0, 6'h07, 32'hF0F0, 32'hFF00, 32'hFFF0, 32'h0, 1'b0, 1});
    tv.push_back('{"nor",      0, 6'h08, 32'h0, 32'h0, 32'hFFFFFFFF, 32'h0, 1'b0, 1});
    tv.push_back('{"mul_neg",  0, 6'h03, 32'hFFFFFFFD, 32'd7, 32'hFFFFFFEB, 32'hFFFFFFFF, 1'b0, 33});
    tv.push_back('{"mul_mn",   0, 6'h03, 32'h80000000, 32'h80000000, 32'h0, 32'h40000000, 1'b0, 33});
    tv.push_back('{"div_neg",  0, 6'h0A, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 32'hFFFFFFFF, 1'b0, 33});
    tv.push_back('{"div_zero", 0, 6'h0A, 32'd9, 32'd0, 32'hFFFFFFFF, 32'd9, 1'b1, 33});
    tv.push_back('{"div_mn",   0, 6'h0A, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'h0, 1'b0, 33});
    tv.push_back('{"ill_0B",   0, 6'h0B, 32'd1, 32'd2, 32'h0, 32'h0, 1'b1, 1});
    tv.push_back('{"ill_21",   0, 6'h21, 32'd1, 32'd2, 32'h0, 32'h0, 1'b1, 1});
    tv.push_back('{"ill_00",   0, 6'h00, 32'd1, 32'd2, 32'h0, 32'h0, 1'b1, 1});
    tv.push_back('{"add8",     1, 6'h01, 32'hFF, 32'h01, 32'h00, 32'h0, 1'b0, 1});
    tv.push_back('{"mul8_neg", 1, 6'h03, 32'hFD, 32'h07, 32'hEB, 32'hFF, 1'b0, 9});
    tv.push_back('{"mul8_mn",  1, 6'h03, 32'h80, 32'h80, 32'h00, 32'h40, 1'b0, 9});
    tv.push_back('{"div8_neg", 1, 6'h0A, 32'hF9, 32'h02, 32'hFD, 32'hFF, 1'b0, 9});
    tv.push_back('{"div8_zero",1, 6'h0A, 32'h09, 32'h00, 32'hFF, 32'h09, 1'b1, 9});
    tv.push_back('{"div8_mn",  1, 6'h0A, 32'h80, 32'hFF, 32'h80, 32'h00, 1'b0, 9});

    foreach (tv[i])
      check_op(tv[i].nm, tv[i].w8, tv[i].op, tv[i].a, tv[i].b, tv[i].eo, tv[i].eh, tv[i].ee, tv[i].lat);

    // START held during BUSY with a different op: must not disturb the multiply.
    prev = out32;
    @(negedge CLK);
    OPRN = 6'h03; OP1 = 32'hFFFFFFFD; OP2 = 32'd7; st32 = 1'b1;
    @(posedge CLK); #1;
    OPRN = 6'h01; OP1 = 32'd1; OP2 = 32'd1;
    lat = 0; held = 1'b1; got = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge CLK);
      lat++;
      if (done32) begin got = 1'b1; break; end
      if (out32 !== prev) held = 1'b0;
      if (lat == 8) st32 = 1'b0;
    end
    st32 = 1'b0;
    chk("ign_done", 64'(got), 64'(1));
    chk("ign_lat",  64'(lat), 64'(33));
    chk("ign_hold", 64'(held), 64'(1));
    chk("ign_out",  64'(out32), 64'(32'hFFFFFFEB));
    chk("ign_hi",   64'(hi32),  64'(32'hFFFFFFFF));

    // Back-to-back: add, add in its DONE cycle, then mul in the second DONE cycle.
    @(negedge CLK);
    OPRN = 6'h01; OP1 = 32'd2; OP2 = 32'd3; st32 = 1'b1;
    @(posedge CLK); #1;
    OP1 = 32'd10; OP2 = 32'd20;
    @(negedge CLK);
    chk("b2b_done1", 64'(done32), 64'(1));
    chk("b2b_out1",  64'(out32),  64'(5));
    @(posedge CLK); #1;
    OPRN = 6'h03; OP1 = 32'hFFFFFFFD; OP2 = 32'd7;
    @(negedge CLK);
    chk("b2b_done2", 64'(done32), 64'(1));
    chk("b2b_out2",  64'(out32),  64'(30));
    @(posedge CLK); #1;
    st32 = 1'b0;
    @(negedge CLK);
    chk("b2b_mul_done0", 64'(done32), 64'(0));
    chk("b2b_mul_busy",  64'(busy32), 64'(1));
    chk("b2b_mul_hold",  64'(out32),  64'(30));
    lat = 1; got = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge CLK);
      lat++;
      if (done32) begin got = 1'b1; break; end
    end
    chk("b2b_mul_lat", 64'(lat),   64'(33));
    chk("b2b_mul_out", 64'(out32), 64'(32'hFFFFFFEB));

    // Reset in the middle of a multiply: abort, no DONE, reset values.
    @(negedge CLK);
    OPRN = 6'h03; OP1 = 32'd5; OP2 = 32'd5; st32 = 1'b1;
    @(posedge CLK); #1;
    st32 = 1'b0;
    repeat (10) @(posedge CLK);
    #1 RST = 1'b1;
    @(posedge CLK); #1;
    RST = 1'b0;
    @(negedge CLK);
    chk("mrst_busy", 64'(busy32), 64'(0));
    chk("mrst_done", 64'(done32), 64'(0));
    chk("mrst_out",  64'(out32),  64'(0));
    chk("mrst_hi",   64'(hi32),   64'(0));
    chk("mrst_zero", 64'(zero32), 64'(1));
    chk("mrst_err",  64'(err32),  64'(0));
    got = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge CLK);
      if (done32 || busy32) got = 1'b1;
    end
    chk("mrst_quiet", 64'(got), 64'(0));
    check_op("post_rst_mul", 0, 6'h03, 32'd6, 32'd7, 32'd42, 32'h0, 1'b0, 33);

    // Randomized ops against the reference model.
    for (int i = 0; i < 150; i++) begin
      bit          w8;
      int          n, k, el;
      logic [5:0]  op;
      logic [31:0] a, b, eo, eh;
      logic        ee;
      w8 = ($urandom_range(0, 3) == 0);
      n  = w8 ? 8 : 32;
      k  = $urandom_range(0, 11);
      if (k < 10)       op = 6'(k + 1);
      else if (k == 10) op = 6'($urandom_range(0, 63));
      else              op = 6'h00;
      a = pick(n);
      b = pick(n);
      model(n, op, a, b, eo, eh, ee, el);
      check_op($sformatf("rnd%0d_w%0d_op%0h", i, n, op), w8, op, a, b, eo, eh, ee, el);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
